multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM of the 16-bit multi-cycle core. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB,
//  drives PC, IR, memory and register-file strobes, and generates the 3-bit select (wb_s2,wb_s1,wb_s0) of the
//  5-input write-back mux (0=ALU result, 1=mem data, 2=PC+1, 3=LUI imm, 4=zero-ext imm; 5..7 illegal, never driven).
// PARAMETERS
//  OPW      4   opcode field width (instr[15:12])
//  AOPW     3   alu_op width
// PORTS
//  clk         in   1     system clock, all state changes on posedge
//  rst_n       in   1     asynchronous active-low reset
//  opcode      in   OPW   IR opcode field, valid from DECODE onward
//  zero        in   1     ALU zero flag, sampled in EXEC for BEQ
//  mem_ready   in   1     memory handshake: access completes in the cycle it is 1
//  pc_write    out  1     PC load strobe
//  pc_src      out  2     00=PC+1, 01=branch target (ALU out), 10=jump target
//  ir_write    out  1     IR load strobe
//  mem_read    out  1     memory read request (fetch or LW)
//  mem_write   out  1     memory write request (SW)
//  i_or_d      out  1     0=address from PC, 1=address from ALU out
//  alu_src_b   out  1     0=register B, 1=immediate
//  alu_op      out  AOPW  000=ADD,001=SUB,010=AND,011=OR,111=funct-decoded (R-type)
//  reg_write   out  1     register-file write strobe
//  wb_s0/s1/s2 out  1     write-back mux select bits
//  halted      out  1     sticky, core stopped
//  illegal     out  1     one-cycle pulse on undefined opcode
//  perf_cycles out  16    cycle counter (see CONFIGURATION)
//  perf_instr  out  16    retired-instruction counter
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=FETCH, all strobes 0, wb select 000, pc_src 00, halted 0, counters 0.
//  - Moore outputs decoded from state register and op_q (opcode latched on entry to EXEC from DECODE).
//  - FETCH: mem_read=1, i_or_d=0. Held while mem_ready=0 (no strobes besides mem_read). Cycle mem_ready=1:
//    ir_write=1, pc_write=1, pc_src=00, next DECODE.
//  - DECODE: opcode decoded; ALU(0),ADDI(1),ANDI(2),LW(3),SW(4),BEQ(5),JMP(6),JAL(7) -> EXEC; LUI(8) -> WB;
//    HALT(15) -> HALT; any other -> illegal=1 for this cycle, next FETCH (treated as NOP).
//  - EXEC: ALU: alu_op=111,alu_src_b=0 -> WB. ADDI/LW/SW: alu_op=000,alu_src_b=1 -> WB(ADDI) or MEM.
//    ANDI: alu_op=010,alu_src_b=1 -> WB. BEQ: alu_op=001, pc_write=zero, pc_src=01 -> FETCH.
//    JMP: pc_write=1,pc_src=10 -> FETCH. JAL: -> WB (jump performed in WB, after link write).
//  - MEM: i_or_d=1; LW mem_read=1, SW mem_write=1; held while mem_ready=0 with request stable.
//    mem_ready=1: SW -> FETCH, LW -> WB.
//  - WB: reg_write=1 one cycle; select: ALU/ADDI/ANDI=000, LW=001, JAL=010 (plus pc_write=1,pc_src=10),
//    LUI=011; -> FETCH. Select code 100 issued for ORI-class zero-ext imm reserved opcode 9 (DECODE->EXEC
//    alu_op=011,alu_src_b=1 -> WB with select 100).
//  - Latency with mem_ready=1: BEQ/JMP/LUI 3 cycles, ALU/ADDI/ANDI/ORI/SW/JAL 4, LW 5.
//  - HALT: absorbing; all strobes 0, halted=1 until reset. mem_ready ignored.
//  - Reset mid-instruction aborts immediately; no partial reg/mem write issued after rst_n deasserts.
//  - Strobes never overlap: mem_read and mem_write never both 1; reg_write only in WB.
// CONFIGURATION
//  MULTICYCLE_PERF_EN defined: perf_cycles increments every non-HALT cycle, perf_instr increments on each
//   transition into FETCH from EXEC/MEM/WB/DECODE(illegal); both wrap 16'hFFFF->0, cleared by reset.
//  Not defined: perf_cycles/perf_instr tied to 16'h0, no counter flops.
// STRUCTURE
//  multicycle_pkg: state enum (FETCH,DECODE,EXEC,MEM,WB,HALT), opcode localparams, WB_SEL_* 3-bit
//   constants, PC_SRC_* and ALU_OP_* constants; shared with datapath and mux instance.
//  Sub-module mc_perf_counters (instantiated only under MULTICYCLE_PERF_EN).
// TESTING
//  1. rst_n=0 mid-EXEC of LW -> all strobes 0, state FETCH, wb sel 000 within same cycle.
//  2. ADD (op 0), mem_ready=1 -> 4 cycles, reg_write=1 in cycle 4 with wb sel 000, perf_instr +1.
//  3. LW, mem_ready low 3 cycles in MEM -> mem_read/i_or_d held 3 cycles, WB sel 001, total 8 cycles.
//  4. BEQ with zero=1 then zero=0 -> pc_write=1/pc_src=01 once, then pc_write=0; 3 cycles each.
//  5. JAL then LUI -> WB sel 010 with pc_src=10, then sel 011; opcode 12 -> illegal pulse, back to FETCH.
//  6. HALT (op 15) -> halted=1 sticky for 20 cycles, perf_cycles frozen, released only by rst_n.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle core control path: states, opcodes,
// write-back selects, PC sources and ALU operations.
package multicycle_pkg;

    localparam int OPW  = 4;
    localparam int AOPW = 3;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ALU  = 4'd0;
    localparam logic [OPW-1:0] OP_ADDI = 4'd1;
    localparam logic [OPW-1:0] OP_ANDI = 4'd2;
    localparam logic [OPW-1:0] OP_LW   = 4'd3;
    localparam logic [OPW-1:0] OP_SW   = 4'd4;
    localparam logic [OPW-1:0] OP_BEQ  = 4'd5;
    localparam logic [OPW-1:0] OP_JMP  = 4'd6;
    localparam logic [OPW-1:0] OP_JAL  = 4'd7;
    localparam logic [OPW-1:0] OP_LUI  = 4'd8;
    localparam logic [OPW-1:0] OP_ORI  = 4'd9;
    localparam logic [OPW-1:0] OP_HALT = 4'd15;

    localparam logic [2:0] WB_SEL_ALU  = 3'b000;
    localparam logic [2:0] WB_SEL_MEM  = 3'b001;
    localparam logic [2:0] WB_SEL_PC1  = 3'b010;
    localparam logic [2:0] WB_SEL_LUI  = 3'b011;
    localparam logic [2:0] WB_SEL_ZEXT = 3'b100;

    localparam logic [1:0] PC_SRC_INC = 2'b00;
    localparam logic [1:0] PC_SRC_BR  = 2'b01;
    localparam logic [1:0] PC_SRC_JMP = 2'b10;

    localparam logic [AOPW-1:0] ALU_OP_ADD   = 3'b000;
    localparam logic [AOPW-1:0] ALU_OP_SUB   = 3'b001;
    localparam logic [AOPW-1:0] ALU_OP_AND   = 3'b010;
    localparam logic [AOPW-1:0] ALU_OP_OR    = 3'b011;
    localparam logic [AOPW-1:0] ALU_OP_FUNCT = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_perf.sv
// Free-running performance counters for the control FSM; both wrap at 16 bits.
// Only instantiated when MULTICYCLE_PERF_EN is defined.
module mc_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cyc_en_i,
    input  logic        ins_en_i,
    output logic [15:0] perf_cycles_o,
    output logic [15:0] perf_instr_o
);

    logic [15:0] cyc_q, cyc_d;
    logic [15:0] ins_q, ins_d;

    always_comb begin
        cyc_d = cyc_en_i ? cyc_q + 16'd1 : cyc_q;
        ins_d = ins_en_i ? ins_q + 16'd1 : ins_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end

    assign perf_cycles_o = cyc_q;
    assign perf_instr_o  = ins_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the 16-bit multi-cycle core (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Optional cycle/instruction counters are enabled by defining MULTICYCLE_PERF_EN.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int AOPW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            ir_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            i_or_d,
    output logic            alu_src_b,
    output logic [AOPW-1:0] alu_op,
    output logic            reg_write,
    output logic            wb_s0,
    output logic            wb_s1,
    output logic            wb_s2,
    output logic            halted,
    output logic            illegal,
    output logic [15:0]     perf_cycles,
    output logic [15:0]     perf_instr
);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q;

    logic            pc_write_c, ir_write_c, mem_read_c, mem_write_c;
    logic            i_or_d_c, alu_src_b_c, reg_write_c, halted_c, illegal_c;
    logic [1:0]      pc_src_c;
    logic [AOPW-1:0] alu_op_c;
    logic [2:0]      wb_sel_c;

    // op_q is captured in every DECODE cycle so WB also sees it for LUI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        pc_src_c    = PC_SRC_INC;
        ir_write_c  = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        i_or_d_c    = 1'b0;
        alu_src_b_c = 1'b0;
        alu_op_c    = ALU_OP_ADD;
        reg_write_c = 1'b0;
        wb_sel_c    = WB_SEL_ALU;
        halted_c    = 1'b0;
        illegal_c   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_ALU, OP_ADDI, OP_ANDI, OP_LW, OP_SW,
                    OP_BEQ, OP_JMP, OP_JAL, OP_ORI: state_d = S_EXEC;
                    OP_LUI:  state_d = S_WB;
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_WB;
                case (op_q)
                    OP_ALU: alu_op_c = ALU_OP_FUNCT;
                    OP_ADDI: alu_src_b_c = 1'b1;
                    OP_LW, OP_SW: begin
                        alu_src_b_c = 1'b1;
                        state_d     = S_MEM;
                    end
                    OP_ANDI: begin
                        alu_op_c    = ALU_OP_AND;
                        alu_src_b_c = 1'b1;
                    end
                    OP_ORI: begin
                        alu_op_c    = ALU_OP_OR;
                        alu_src_b_c = 1'b1;
                    end
                    OP_BEQ: begin
                        alu_op_c   = ALU_OP_SUB;
                        pc_write_c = zero;
                        pc_src_c   = PC_SRC_BR;
                        state_d    = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = PC_SRC_JMP;
                        state_d    = S_FETCH;
                    end
                    OP_JAL: state_d = S_WB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                i_or_d_c    = 1'b1;
                mem_read_c  = (op_q == OP_LW);
                mem_write_c = (op_q == OP_SW);
                if (mem_ready) begin
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
                case (op_q)
                    OP_LW:  wb_sel_c = WB_SEL_MEM;
                    OP_LUI: wb_sel_c = WB_SEL_LUI;
                    OP_ORI: wb_sel_c = WB_SEL_ZEXT;
                    OP_JAL: begin
                        wb_sel_c   = WB_SEL_PC1;
                        pc_write_c = 1'b1;
                        pc_src_c   = PC_SRC_JMP;
                    end
                    default: wb_sel_c = WB_SEL_ALU;
                endcase
            end
            S_HALT: halted_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset silences every strobe immediately, even the FETCH read request.
    always_comb begin
        pc_write  = rst_n & pc_write_c;
        pc_src    = rst_n ? pc_src_c : PC_SRC_INC;
        ir_write  = rst_n & ir_write_c;
        mem_read  = rst_n & mem_read_c;
        mem_write = rst_n & mem_write_c;
        i_or_d    = rst_n & i_or_d_c;
        alu_src_b = rst_n & alu_src_b_c;
        alu_op    = rst_n ? alu_op_c : ALU_OP_ADD;
        reg_write = rst_n & reg_write_c;
        wb_s0     = rst_n & wb_sel_c[0];
        wb_s1     = rst_n & wb_sel_c[1];
        wb_s2     = rst_n & wb_sel_c[2];
        halted    = rst_n & halted_c;
        illegal   = rst_n & illegal_c;
    end

`ifdef MULTICYCLE_PERF_EN
    mc_perf_counters u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .cyc_en_i     (state_q != S_HALT),
        .ins_en_i     ((state_d == S_FETCH) && (state_q != S_FETCH)),
        .perf_cycles_o(perf_cycles),
        .perf_instr_o (perf_instr)
    );
`else
    assign perf_cycles = 16'h0;
    assign perf_instr  = 16'h0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction phase lists model the expected
// strobes every cycle; directed latency/reset/halt cases plus random traffic.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, mem_read, mem_write, i_or_d;
    logic        alu_src_b, reg_write, wb_s0, wb_s1, wb_s2, halted, illegal;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic [15:0] perf_cycles, perf_instr;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .wb_s0      (wb_s0),
        .wb_s1      (wb_s1),
        .wb_s2      (wb_s2),
        .halted     (halted),
        .illegal    (illegal),
        .perf_cycles(perf_cycles),
        .perf_instr (perf_instr)
    );

    always #5 clk = ~clk;

`ifdef MULTICYCLE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int PH_F = 0;
    localparam int PH_D = 1;
    localparam int PH_X = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;
    localparam int PH_H = 5;

    int          errors = 0;
    int          checks = 0;
    int          q[$];
    logic [3:0]  m_op;
    bit          m_rst = 1'b1;
    bit          m_done;
    logic [15:0] m_cyc = '0;
    logic [15:0] m_ins = '0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Remaining phases of one instruction, purely from its opcode.
    task automatic plan(input logic [3:0] op);
        q.delete();
        m_op = op;
        q.push_back(PH_F);
        q.push_back(PH_D);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd7, 4'd9: begin q.push_back(PH_X); q.push_back(PH_W); end
            4'd3: begin q.push_back(PH_X); q.push_back(PH_M); q.push_back(PH_W); end
            4'd4: begin q.push_back(PH_X); q.push_back(PH_M); end
            4'd5, 4'd6: q.push_back(PH_X);
            4'd8: q.push_back(PH_W);
            default: ;
        endcase
    endtask

    task automatic model_adv(input logic mr);
        int ph;
        m_done = 1'b0;
        if (m_rst) return;
        ph = q[0];
        if (ph == PH_H) return;
        m_cyc = m_cyc + 16'd1;
        if (ph == PH_F || ph == PH_M) begin
            if (mr) void'(q.pop_front());
        end else if (ph == PH_D && m_op == 4'd15) begin
            q.delete();
            q.push_back(PH_H);
        end else begin
            void'(q.pop_front());
        end
        if (q.size() == 0) begin
            m_ins  = m_ins + 16'd1;
            m_done = 1'b1;
            plan(4'($urandom_range(0, 14)));
        end
    endtask

    task automatic check();
        int         ph;
        logic [3:0] op;
        logic       er, ew, eid, eir, epw, esb, erw, eill, eh;
        logic [1:0] eps;
        logic [2:0] eao, esel;
        ph = q[0];
        op = m_op;
        er = 0; ew = 0; eid = 0; eir = 0; epw = 0; esb = 0;
        erw = 0; eill = 0; eh = 0; eps = 0; eao = 0; esel = 0;
        if (!m_rst) begin
            er   = (ph == PH_F) || (ph == PH_M && op == 4'd3);
            ew   = (ph == PH_M && op == 4'd4);
            eid  = (ph == PH_M);
            eir  = (ph == PH_F) && mem_ready;
            epw  = ((ph == PH_F) && mem_ready) || (ph == PH_X && op == 4'd5 && zero)
                || (ph == PH_X && op == 4'd6) || (ph == PH_W && op == 4'd7);
            if (ph == PH_X && op == 4'd5) eps = 2'd1;
            if ((ph == PH_X && op == 4'd6) || (ph == PH_W && op == 4'd7)) eps = 2'd2;
            esb  = (ph == PH_X) && (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9});
            if (ph == PH_X) begin
                case (op)
                    4'd0: eao = 3'd7;
                    4'd2: eao = 3'd2;
                    4'd5: eao = 3'd1;
                    4'd9: eao = 3'd3;
                    default: eao = 3'd0;
                endcase
            end
            erw  = (ph == PH_W);
            if (ph == PH_W) begin
                case (op)
                    4'd3: esel = 3'd1;
                    4'd7: esel = 3'd2;
                    4'd8: esel = 3'd3;
                    4'd9: esel = 3'd4;
                    default: esel = 3'd0;
                endcase
            end
            eill = (ph == PH_D) && (op inside {[4'd10:4'd14]});
            eh   = (ph == PH_H);
        end
        chk("mem_read", 16'(mem_read), 16'(er));
        chk("mem_write", 16'(mem_write), 16'(ew));
        chk("i_or_d", 16'(i_or_d), 16'(eid));
        chk("ir_write", 16'(ir_write), 16'(eir));
        chk("pc_write", 16'(pc_write), 16'(epw));
        chk("pc_src", 16'(pc_src), 16'(eps));
        chk("alu_src_b", 16'(alu_src_b), 16'(esb));
        chk("alu_op", 16'(alu_op), 16'(eao));
        chk("reg_write", 16'(reg_write), 16'(erw));
        chk("wb_sel", 16'({wb_s2, wb_s1, wb_s0}), 16'(esel));
        chk("illegal", 16'(illegal), 16'(eill));
        chk("halted", 16'(halted), 16'(eh));
        chk("rd_wr_excl", 16'(mem_read & mem_write), 16'd0);
        chk("perf_cycles", perf_cycles, PERF ? m_cyc : 16'd0);
        chk("perf_instr", perf_instr, PERF ? m_ins : 16'd0);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic mr, input logic z);
        mem_ready = mr;
        zero      = z;
        opcode    = m_op;
        #1 check();
        model_adv(mr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold_reset();
        rst_n     = 1'b0;
        m_rst     = 1'b1;
        mem_ready = 1'b0;
        repeat (2) begin
            #1 check();
            @(negedge clk);
        end
        rst_n = 1'b1;
        m_rst = 1'b0;
        m_cyc = '0;
        m_ins = '0;
        plan(4'($urandom_range(0, 14)));
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input int waits, input int exp_n);
        int   n;
        int   w;
        logic mr;
        n = 0;
        w = waits;
        m_done = 1'b0;
        plan(op);
        while (!m_done && n < 40) begin
            mr = 1'b1;
            if (q[0] == PH_M && w > 0) begin
                mr = 1'b0;
                w--;
            end
            step(mr, z);
            n++;
        end
        chk($sformatf("latency_op%0d", op), 16'(n), 16'(exp_n));
    endtask

    initial begin
        int k;
        @(negedge clk);
        hold_reset();

        run_instr(4'd0, 1'b0, 0, 4);
        chk("add_perf_instr", perf_instr, PERF ? 16'd1 : 16'd0);
        run_instr(4'd3, 1'b0, 3, 8);
        run_instr(4'd5, 1'b1, 0, 3);
        run_instr(4'd5, 1'b0, 0, 3);
        run_instr(4'd7, 1'b0, 0, 4);
        run_instr(4'd8, 1'b0, 0, 3);
        run_instr(4'd12, 1'b0, 0, 2);
        chk("perf_cycles_lit", perf_cycles, PERF ? 16'd27 : 16'd0);
        chk("perf_instr_lit", perf_instr, PERF ? 16'd7 : 16'd0);

        plan(4'd3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        hold_reset();

        repeat (3000) step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));

        k = 0;
        m_done = 1'b0;
        while (!m_done && k < 20) begin
            step(1'b1, 1'b0);
            k++;
        end
        plan(4'd15);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        repeat (20) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("halted_sticky", 16'(halted), 16'd1);

        hold_reset();
        #1 chk("halt_released", 16'(halted), 16'd0);
        step(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
